// File: rtl/ternary_systolic_stream_pkg.sv
// Shared definitions for the ternary systolic stream array:
// weight codes, controller states and the ternary multiply used by every PE.
package ternary_pkg;

  localparam logic [1:0] W_ZERO = 2'b00;
  localparam logic [1:0] W_POS  = 2'b01;
  localparam logic [1:0] W_NEG  = 2'b11;

  // Wide enough for any supported ACC_W; callers truncate to their own width.
  localparam int MUL_W = 64;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Code 2'b10 is reserved and, like 2'b00, contributes nothing.
  function automatic logic signed [MUL_W-1:0] tern_mul(input logic signed [MUL_W-1:0] x,
                                                       input logic [1:0] w);
    logic signed [MUL_W-1:0] p;
    case (w)
      W_POS:   p = x;
      W_NEG:   p = -x;
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/ternary_systolic_stream_if.sv
// Operand beat stream in, Y row stream out, plus the busy flag.
// The master drives operands and out_ready; the slave is the array.
interface ternary_systolic_stream_if #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int WIDTH = 16,
  parameter int ACC_W = 2 * WIDTH
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                   in_valid;
  logic                   in_ready;
  logic [ROWS*WIDTH-1:0]  in_x;
  logic [COLS*2-1:0]      in_w;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [COLS*ACC_W-1:0]  out_y;
  logic [RW-1:0]          out_row;
  logic                   out_last;
  logic                   busy;

  modport master (
    output in_valid, in_x, in_w, in_last, out_ready,
    input  in_ready, out_valid, out_y, out_row, out_last, busy
  );

  modport slave (
    input  in_valid, in_x, in_w, in_last, out_ready,
    output in_ready, out_valid, out_y, out_row, out_last, busy
  );

endinterface

// File: rtl/ternary_systolic_stream_pe.sv
// One output-stationary MAC cell: accumulates x * w (w ternary) and forwards
// x to the right and w downward through one register each.
module ternary_pe
  import ternary_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ACC_W = 2 * WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic [1:0]              w_in,
  output logic signed [WIDTH-1:0] x_out,
  output logic [1:0]              w_out,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [WIDTH-1:0] x_r;
  logic [1:0]              w_r;
  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] prod_s;

  // Truncation to ACC_W gives plain two's-complement wrap on accumulate.
  assign prod_s = ACC_W'(tern_mul(MUL_W'(x_in), w_in));

  // Operand forwarding and accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r   <= '0;
      w_r   <= W_ZERO;
      acc_r <= '0;
    end else if (clr) begin
      x_r   <= '0;
      w_r   <= W_ZERO;
      acc_r <= '0;
    end else begin
      x_r   <= x_in;
      w_r   <= w_in;
      acc_r <= acc_r + prod_s;
    end
  end

  assign x_out = x_r;
  assign w_out = w_r;
  assign acc   = acc_r;

endmodule

// File: rtl/ternary_systolic_stream.sv
// ROWS x COLS output-stationary systolic array computing Y = X * W with ternary W,
// fed by a valid/ready beat stream and drained one Y row per handshake.
module ternary_systolic_stream
  import ternary_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int ACC_W = 2 * WIDTH,
  parameter int MAX_K = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  ternary_systolic_stream_if.slave stream
);

  localparam int K_W  = (MAX_K > 1) ? $clog2(MAX_K) : 1;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FL_N = ROWS + COLS - 1;
  localparam int FL_W = $clog2(FL_N + 1);

  state_t           state_r, state_s;
  logic [K_W-1:0]   beat_r, beat_s;
  logic [FL_W-1:0]  flush_r, flush_s;
  logic [RW-1:0]    row_r, row_s;

  logic in_ready_s, accept_s, out_hs_s, final_hs_s, pe_clr_s;

  logic signed [WIDTH-1:0] x_inj_s  [ROWS];
  logic [1:0]              w_inj_s  [COLS];
  logic signed [WIDTH-1:0] x_link_s [ROWS][COLS+1];
  logic [1:0]              w_link_s [ROWS+1][COLS];
  logic signed [ACC_W-1:0] acc_s    [ROWS][COLS];
  logic                    edge_unused_s;

  logic [COLS*ACC_W-1:0] y_next_s, out_y_r;
  logic                  out_valid_r, out_last_r, busy_r;

  // Beats are only taken in LOAD, never in the abort cycle, never during reset.
  assign in_ready_s = rst_n && (state_r == LOAD) && !clear;
  assign accept_s   = stream.in_valid && in_ready_s;
  assign out_hs_s   = (state_r == DRAIN) && stream.out_ready && !clear;
  assign final_hs_s = out_hs_s && (row_r == RW'(ROWS - 1));
  assign pe_clr_s   = clear || final_hs_s;

  // Accepted beat, or a zero-product bubble, at the skew inputs
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      x_inj_s[r] = accept_s ? stream.in_x[r*WIDTH +: WIDTH] : '0;
    end
    for (int c = 0; c < COLS; c++) begin
      w_inj_s[c] = accept_s ? stream.in_w[c*2 +: 2] : W_ZERO;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_x_skew
    if (r == 0) begin : g_direct
      assign x_link_s[r][0] = x_inj_s[r];
    end else begin : g_delay
      logic signed [WIDTH-1:0] sk_r [r];
      // r-stage delay line so row r meets its weights r cycles late
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < r; i++) sk_r[i] <= '0;
        end else if (clear) begin
          for (int i = 0; i < r; i++) sk_r[i] <= '0;
        end else begin
          sk_r[0] <= x_inj_s[r];
          for (int i = 1; i < r; i++) sk_r[i] <= sk_r[i-1];
        end
      end
      assign x_link_s[r][0] = sk_r[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_w_skew
    if (c == 0) begin : g_direct
      assign w_link_s[0][c] = w_inj_s[c];
    end else begin : g_delay
      logic [1:0] sk_r [c];
      // c-stage delay line so column c meets its inputs c cycles late
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < c; i++) sk_r[i] <= W_ZERO;
        end else if (clear) begin
          for (int i = 0; i < c; i++) sk_r[i] <= W_ZERO;
        end else begin
          sk_r[0] <= w_inj_s[c];
          for (int i = 1; i < c; i++) sk_r[i] <= sk_r[i-1];
        end
      end
      assign w_link_s[0][c] = sk_r[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      ternary_pe #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
      ) u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (pe_clr_s),
        .x_in  (x_link_s[r][c]),
        .w_in  (w_link_s[r][c]),
        .x_out (x_link_s[r][c+1]),
        .w_out (w_link_s[r+1][c]),
        .acc   (acc_s[r][c])
      );
    end
  end

  // Operands leaving the far edges are dropped; fold them into one ignored bit
  always_comb begin
    edge_unused_s = 1'b0;
    for (int r = 0; r < ROWS; r++) edge_unused_s = edge_unused_s ^ (^x_link_s[r][COLS]);
    for (int c = 0; c < COLS; c++) edge_unused_s = edge_unused_s ^ (^w_link_s[ROWS][c]);
  end

  // Next state and counters; clear overrides everything
  always_comb begin
    state_s = state_r;
    beat_s  = beat_r;
    flush_s = flush_r;
    row_s   = row_r;
    if (clear) begin
      state_s = LOAD;
      beat_s  = '0;
      flush_s = '0;
      row_s   = '0;
    end else begin
      case (state_r)
        LOAD: begin
          if (accept_s) begin
            if (stream.in_last || (beat_r == K_W'(MAX_K - 1))) begin
              state_s = FLUSH;
              beat_s  = '0;
            end else begin
              beat_s = beat_r + K_W'(1);
            end
          end else begin
            beat_s = beat_r;
          end
        end
        FLUSH: begin
          if (flush_r == FL_W'(FL_N - 1)) begin
            state_s = DRAIN;
            flush_s = '0;
            row_s   = '0;
          end else begin
            flush_s = flush_r + FL_W'(1);
          end
        end
        DRAIN: begin
          if (final_hs_s) begin
            state_s = LOAD;
            row_s   = '0;
          end else if (out_hs_s) begin
            row_s = row_r + RW'(1);
          end else begin
            row_s = row_r;
          end
        end
        default: begin
          state_s = LOAD;
          beat_s  = '0;
          flush_s = '0;
          row_s   = '0;
        end
      endcase
    end
  end

  // Controller state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= LOAD;
      beat_r  <= '0;
      flush_r <= '0;
      row_r   <= '0;
    end else begin
      state_r <= state_s;
      beat_r  <= beat_s;
      flush_r <= flush_s;
      row_r   <= row_s;
    end
  end

  // Row that will be presented next cycle; accumulators are frozen in DRAIN
  always_comb begin
    y_next_s = '0;
    for (int c = 0; c < COLS; c++) begin
      y_next_s[c*ACC_W +: ACC_W] = acc_s[row_s][c];
    end
  end

  // Registered output row and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      out_y_r     <= '0;
    end else begin
      out_valid_r <= (state_s == DRAIN);
      out_last_r  <= (state_s == DRAIN) && (row_s == RW'(ROWS - 1));
      busy_r      <= (state_s != LOAD);
      out_y_r     <= (state_s == DRAIN) ? y_next_s : '0;
    end
  end

  assign stream.in_ready  = in_ready_s;
  assign stream.out_valid = out_valid_r;
  assign stream.out_last  = out_last_r;
  assign stream.out_row   = row_r;
  assign stream.out_y     = out_y_r;
  assign stream.busy      = busy_r;

endmodule
